pr_capture_fifo: RTL and testbench

PR_CAPTURE_FIFO -- requirements
Module: pr_capture_fifo

---
 rtl/pipe_pkg.sv | 14 +
 rtl/sync_fifo.sv | 97 +++++++++
 rtl/pr_capture_fifo.sv | 89 ++++++++
 tb/tb_pr_capture_fifo.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared defaults and types for the pipeline-register capture FIFO.
package pipe_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int CNT_WIDTH      = 16;

  // Occupancy state of the capture FIFO
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO: storage, wrapping pointers, occupancy FSM and flags.
// A pop only succeeds on a non-empty FIFO; a push on full succeeds only
// when paired with a same-cycle pop. flush beats both.
module sync_fifo
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 4
) (
  input  logic                    fast_clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic                    push_drop,
  output logic                    pop_ok
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count_nxt;
  logic                  do_wr, do_rd;
  occ_state_e            state, state_nxt;

  // Qualify push/pop against occupancy and flush
  always_comb begin
    do_rd     = pop && !empty && !flush;
    do_wr     = push && !flush && (!full || do_rd);
    push_drop = push && !flush && full && !do_rd;
    pop_ok    = do_rd;
    count_nxt = flush ? '0 : count + CW'(do_wr) - CW'(do_rd);
  end

  // Pointers and count; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_wr) wr_ptr <= wr_ptr + AW'(1);
        if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Storage array, not reset
  always_ff @(posedge fast_clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

  // Occupancy state register
  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) state <= OCC_EMPTY;
    else        state <= state_nxt;
  end

  // Occupancy next state from net push-minus-pop
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = OCC_EMPTY;
    end else begin
      case (state)
        OCC_EMPTY:   if (do_wr) state_nxt = OCC_PARTIAL;
        OCC_PARTIAL: begin
          if (do_wr && !do_rd && count == CW'(DEPTH - 1)) state_nxt = OCC_FULL;
          else if (do_rd && !do_wr && count == CW'(1))    state_nxt = OCC_EMPTY;
        end
        OCC_FULL:    if (do_rd && !do_wr) state_nxt = OCC_PARTIAL;
        default:     state_nxt = OCC_EMPTY;
      endcase
    end
  end

  // Flags decoded from occupancy state
  always_comb begin
    full  = (state == OCC_FULL);
    empty = (state == OCC_EMPTY);
  end

endmodule

// File: rtl/pr_capture_fifo.sv
// Pipeline register fed by a capture FIFO: Stage 1 pushes on fast_clk,
// Stage 2 takes one value per slow_clk period at the falling edge of the
// (data-sampled) slow clock. Tracks dropped pushes and empty commits.
module pr_capture_fifo
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 4
) (
  input  logic                    fast_clk,
  input  logic                    rst_n,
  input  logic                    slow_clk,
  input  logic [DATA_WIDTH-1:0]   s1_data,
  input  logic                    s1_data_ready,
  input  logic                    flush,
  output logic [DATA_WIDTH-1:0]   pr_data_out,
  output logic                    pr_valid,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    fifo_full,
  output logic                    fifo_empty,
  output logic [CNT_WIDTH-1:0]    overflow_cnt,
  output logic [CNT_WIDTH-1:0]    underflow_cnt,
  output logic                    overflow_err
);

  logic                  slow_q;
  logic                  commit_stb;
  logic                  pop_ok, push_drop;
  logic [DATA_WIDTH-1:0] head;

  // slow_clk is only data; remember last sample to find its falling edge
  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) slow_q <= 1'b0;
    else        slow_q <= slow_clk;
  end

  assign commit_stb = slow_q & ~slow_clk;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .fast_clk  (fast_clk),
    .rst_n     (rst_n),
    .push      (s1_data_ready),
    .pop       (commit_stb),
    .flush     (flush),
    .wr_data   (s1_data),
    .rd_data   (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .push_drop (push_drop),
    .pop_ok    (pop_ok)
  );

  // Output register: loads the head on a real pop, otherwise holds data and drops valid
  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      pr_data_out <= '0;
      pr_valid    <= 1'b0;
    end else if (commit_stb) begin
      if (pop_ok) begin
        pr_data_out <= head;
        pr_valid    <= 1'b1;
      end else begin
        pr_valid    <= 1'b0;
      end
    end
  end

  // Saturating drop/underflow statistics and sticky overflow flag
  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_cnt  <= '0;
      underflow_cnt <= '0;
      overflow_err  <= 1'b0;
    end else begin
      if (push_drop) begin
        overflow_err <= 1'b1;
        if (overflow_cnt != '1) overflow_cnt <= overflow_cnt + 1'b1;
      end
      // an empty FIFO or a same-cycle flush leaves the commit with nothing to take
      if (commit_stb && !pop_ok && underflow_cnt != '1)
        underflow_cnt <= underflow_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pr_capture_fifo.sv
// Bench for pr_capture_fifo: a queue holds every accepted push; each commit
// pops the queue and the popped value is what pr_data_out must show.
module tb_pr_capture_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          fast_clk = 1'b0;
  logic          rst_n;
  logic          slow_clk;
  logic [DW-1:0] s1_data;
  logic          s1_data_ready;
  logic          flush;
  logic [DW-1:0] pr_data_out;
  logic          pr_valid;
  logic [2:0]    fifo_count;
  logic          fifo_full, fifo_empty;
  logic [15:0]   overflow_cnt, underflow_cnt;
  logic          overflow_err;

  pr_capture_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .fast_clk      (fast_clk),
    .rst_n         (rst_n),
    .slow_clk      (slow_clk),
    .s1_data       (s1_data),
    .s1_data_ready (s1_data_ready),
    .flush         (flush),
    .pr_data_out   (pr_data_out),
    .pr_valid      (pr_valid),
    .fifo_count    (fifo_count),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .overflow_cnt  (overflow_cnt),
    .underflow_cnt (underflow_cnt),
    .overflow_err  (overflow_err)
  );

  always #5 fast_clk = ~fast_clk;

  int n_vec = 0;
  int n_err = 0;

  // reference state
  logic [DW-1:0] mq[$];
  logic          m_slow_q;
  logic          m_valid;
  logic [DW-1:0] m_data;
  int            m_ovf, m_unf;
  logic          m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("count",    32'(fifo_count),    32'(mq.size()));
    chk("full",     32'(fifo_full),     32'(mq.size() == DEPTH));
    chk("empty",    32'(fifo_empty),    32'(mq.size() == 0));
    chk("valid",    32'(pr_valid),      32'(m_valid));
    chk("data",     32'(pr_data_out),   32'(m_data));
    chk("ovf_cnt",  32'(overflow_cnt),  32'(m_ovf));
    chk("unf_cnt",  32'(underflow_cnt), 32'(m_unf));
    chk("ovf_err",  32'(overflow_err),  32'(m_err));
  endtask

  task automatic model_reset();
    mq.delete();
    m_slow_q = 1'b0;
    m_valid  = 1'b0;
    m_data   = '0;
    m_ovf    = 0;
    m_unf    = 0;
    m_err    = 1'b0;
  endtask

  // one fast_clk cycle; called just after a negedge
  task automatic step(input logic p, input logic [DW-1:0] d, input logic fl, input logic sc);
    logic commit;
    s1_data_ready = p;
    s1_data       = d;
    flush         = fl;
    slow_clk      = sc;
    commit   = m_slow_q && !sc;
    m_slow_q = sc;
    if (commit) begin
      if (!fl && mq.size() > 0) begin
        m_data  = mq.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
        if (m_unf < 65535) m_unf++;
      end
    end
    if (fl) mq.delete();
    else if (p) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else begin
        if (m_ovf < 65535) m_ovf++;
        m_err = 1'b1;
      end
    end
    @(posedge fast_clk);
    #1;
    check_all();
    @(negedge fast_clk);
  endtask

  // one divide-by-4 slow_clk period: high, high, low (commit), low
  task automatic slow_period();
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s1_data_ready = 1'b0;
    flush = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge fast_clk);
    @(negedge fast_clk);
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    slow_clk = 1'b0;
    s1_data = '0;
    s1_data_ready = 1'b0;
    flush = 1'b0;
    model_reset();
    @(negedge fast_clk);
    do_reset();

    // two pushes ahead of one slow fall, then drained in order
    step(1'b1, 8'h11, 1'b0, 1'b1);
    step(1'b1, 8'h22, 1'b0, 1'b1);
    slow_period();
    chk("first_pop", 32'(pr_data_out), 32'h11);
    slow_period();
    chk("second_pop", 32'(pr_data_out), 32'h22);
    chk("drained", 32'(fifo_count), 32'd0);

    // two empty commits: data holds, valid drops
    slow_period();
    slow_period();
    chk("held_data", 32'(pr_data_out), 32'h22);
    chk("unf_two", 32'(underflow_cnt), 32'd2);

    // overfill with six pushes, no commit
    for (int i = 1; i <= 6; i++) step(1'b1, DW'(i), 1'b0, 1'b1);
    chk("ovf_two", 32'(overflow_cnt), 32'd2);
    chk("full_flag", 32'(fifo_full), 32'd1);
    for (int i = 0; i < 4; i++) slow_period();
    chk("last_of_four", 32'(pr_data_out), 32'h04);

    // full FIFO, push coincident with a commit
    for (int i = 0; i < 4; i++) step(1'b1, DW'(8'h30 + i), 1'b0, 1'b1);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("full_pushpop_cnt", 32'(fifo_count), 32'd4);
    chk("full_pushpop_ovf", 32'(overflow_cnt), 32'd2);
    for (int i = 0; i < 4; i++) slow_period();
    chk("aa_last", 32'(pr_data_out), 32'hAA);

    // push together with flush on three queued entries
    for (int i = 0; i < 3; i++) step(1'b1, DW'(8'h40 + i), 1'b0, 1'b1);
    step(1'b1, 8'h4F, 1'b1, 1'b1);
    chk("flush_cnt", 32'(fifo_count), 32'd0);
    chk("flush_keep_data", 32'(pr_data_out), 32'hAA);

    // flush coincident with commit counts as underflow
    step(1'b1, 8'h50, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_commit_vld", 32'(pr_valid), 32'd0);

    // push and commit together on an empty FIFO: no bypass
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    chk("empty_pushpop_cnt", 32'(fifo_count), 32'd1);
    slow_period();
    chk("empty_pushpop_data", 32'(pr_data_out), 32'h33);

    // reset mid-operation with two entries queued
    step(1'b1, 8'h61, 1'b0, 1'b1);
    step(1'b1, 8'h62, 1'b0, 1'b1);
    do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("no_commit_after_rst", 32'(underflow_cnt), 32'd0);
    step(1'b1, 8'h05, 1'b0, 1'b0);
    slow_period();
    chk("fresh_push", 32'(pr_data_out), 32'h05);

    // free-running divide-by-4 with random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 35), DW'($urandom), ($urandom_range(0, 39) == 0),
           ((i % 4) < 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000");
    $fatal(1);
  end

endmodule
